// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scan-out reads win by default, while a
// bounded streak of display grants guarantees the CPU a slot when it waits.
module vram_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 8,
  parameter int MAX_STREAK = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_gnt,
  output logic              o_disp_rvalid,
  output logic [DATA_W-1:0] o_disp_rdata,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_gnt,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [31:0]       o_cpu_stall_cnt
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);

  logic [STREAK_W-1:0] r_streak;
  logic                r_disp_rvalid;
  logic                r_cpu_rvalid;
  logic [ADDR_W-1:0]   r_last_addr;
  logic [31:0]         r_stall_cnt;

  logic w_cpu_forced;
  logic w_disp_gnt;
  logic w_cpu_gnt;
  logic w_stall;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_disp_gnt   = 1'b0;
    w_cpu_gnt    = 1'b0;
    w_cpu_forced = (r_streak == STREAK_W'(MAX_STREAK));
    if (!i_reset) begin
      if (i_disp_req && !(i_cpu_req && w_cpu_forced)) begin
        w_disp_gnt = 1'b1;
      end else if (i_cpu_req) begin
        w_cpu_gnt = 1'b1;
      end
    end
  end

  assign w_stall = i_cpu_req & ~w_cpu_gnt & ~i_reset;

  assign o_disp_gnt   = w_disp_gnt;
  assign o_cpu_gnt    = w_cpu_gnt;
  assign o_mem_we     = w_cpu_gnt & i_cpu_we;
  assign o_mem_wdata  = i_cpu_wdata;
  assign o_mem_addr   = w_disp_gnt ? i_disp_addr :
                        w_cpu_gnt  ? i_cpu_addr  : r_last_addr;

  // Masking with reset keeps a read granted just before reset from ever surfacing.
  assign o_disp_rvalid   = r_disp_rvalid & ~i_reset;
  assign o_cpu_rvalid    = r_cpu_rvalid & ~i_reset;
  assign o_disp_rdata    = i_mem_rdata;
  assign o_cpu_rdata     = i_mem_rdata;
  assign o_cpu_stall_cnt = r_stall_cnt;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_streak      <= '0;
      r_disp_rvalid <= 1'b0;
      r_cpu_rvalid  <= 1'b0;
      r_stall_cnt   <= '0;
      r_last_addr   <= '0;
    end else begin
      r_disp_rvalid <= w_disp_gnt;
      r_cpu_rvalid  <= w_cpu_gnt & ~i_cpu_we;
      r_last_addr   <= o_mem_addr;
      if (!i_cpu_req || w_cpu_gnt) begin
        r_streak <= '0;
      end else if (w_disp_gnt) begin
        r_streak <= r_streak + 1'b1;
      end
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a small behavioural VRAM (one-cycle
// registered read) preloaded with addr ^ 0x5A.
module tb_vram_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [31:0]       stall_cnt;

  logic [DATA_W-1:0] vram [0:255];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STREAK(4)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_disp_req(disp_req), .i_disp_addr(disp_addr), .o_disp_gnt(disp_gnt),
    .o_disp_rvalid(disp_rvalid), .o_disp_rdata(disp_rdata),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid),
    .o_cpu_rdata(cpu_rdata), .o_mem_addr(mem_addr), .o_mem_we(mem_we),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .o_cpu_stall_cnt(stall_cnt)
  );

  always @(posedge clk) begin
    if (mem_we) vram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= vram[mem_addr[7:0]];
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; disp_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    disp_addr = '0; cpu_addr = '0; cpu_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({disp_gnt, cpu_gnt, disp_rvalid, cpu_rvalid, mem_we} !== 5'b0) begin
      bad++; $display("FAIL reset_idle got=%b want=00000", {disp_gnt, cpu_gnt, disp_rvalid, cpu_rvalid, mem_we});
    end
    total++;
    if (stall_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_stall got=%0d want=0", stall_cnt);
    end
  endtask

  task automatic test_display_stream();
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      disp_req  = (i < 8);
      disp_addr = ADDR_W'(i);
      #1;
      if (i < 8) begin
        total++;
        if (disp_gnt !== 1'b1 || mem_we !== 1'b0) begin
          bad++; $display("FAIL disp_gnt[%0d] got=%b we=%b want=1 we=0", i, disp_gnt, mem_we);
        end
      end
      total++;
      if (i == 0) begin
        if (disp_rvalid !== 1'b0) begin
          bad++; $display("FAIL disp_rvalid_first got=%b want=0", disp_rvalid);
        end
      end else if (disp_rvalid !== 1'b1 || disp_rdata !== (8'(i - 1) ^ 8'h5A)) begin
        bad++; $display("FAIL disp_rdata[%0d] got=%b/%h want=1/%h", i - 1, disp_rvalid, disp_rdata, 8'(i - 1) ^ 8'h5A);
      end
    end
    total++;
    if (stall_cnt !== 32'd0) begin
      bad++; $display("FAIL disp_stall got=%0d want=0", stall_cnt);
    end
  endtask

  task automatic test_cpu_write_read();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd100; cpu_wdata = 8'h3C;
    #1;
    total++;
    if (cpu_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd100) begin
      bad++; $display("FAIL cpu_wr_gnt got=%b/%b/%0d want=1/1/100", cpu_gnt, mem_we, mem_addr);
    end
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    total++;
    if (cpu_gnt !== 1'b1 || cpu_rvalid !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL cpu_rd_gnt got=%b rv=%b we=%b want=1 rv=0 we=0", cpu_gnt, cpu_rvalid, mem_we);
    end
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    total++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h3C) begin
      bad++; $display("FAIL cpu_rdata got=%b/%h want=1/3c", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      disp_req = 1'b1; disp_addr = ADDR_W'(c);
      cpu_req = (c <= 5); cpu_we = 1'b0; cpu_addr = 32'd7;
      #1;
      total++;
      if (c == 5) begin
        if (cpu_gnt !== 1'b1 || disp_gnt !== 1'b0 || mem_addr !== 32'd7) begin
          bad++; $display("FAIL cont_cpu c=%0d got=%b%b want=01", c, disp_gnt, cpu_gnt);
        end
      end else if (disp_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
        bad++; $display("FAIL cont_disp c=%0d got=%b%b want=10", c, disp_gnt, cpu_gnt);
      end
    end
    total++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5D) begin
      bad++; $display("FAIL cont_rdata got=%b/%h want=1/5d", cpu_rvalid, cpu_rdata);
    end
    total++;
    if (stall_cnt !== 32'd4) begin
      bad++; $display("FAIL cont_stall got=%0d want=4", stall_cnt);
    end
    @(negedge clk);
    disp_req = 1'b0;
  endtask

  task automatic test_cpu_drop();
    logic exp_cpu;
    do_reset();
    // cycles 1-2 both request, 3 display only, 4-7 display wins, 8 CPU forced
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      disp_req = 1'b1; disp_addr = ADDR_W'(c);
      cpu_req = (c != 3); cpu_we = 1'b0; cpu_addr = 32'd9;
      exp_cpu = (c == 8);
      #1;
      total++;
      if (cpu_gnt !== exp_cpu || disp_gnt !== ~exp_cpu) begin
        bad++; $display("FAIL drop c=%0d got=%b%b want=%b%b", c, disp_gnt, cpu_gnt, ~exp_cpu, exp_cpu);
      end
    end
    @(negedge clk);
    disp_req = 1'b0; cpu_req = 1'b0;
    #1;
    total++;
    if (stall_cnt !== 32'd6) begin
      bad++; $display("FAIL drop_stall got=%0d want=6", stall_cnt);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd50; cpu_wdata = 8'h77;
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 32'd100;
    #1;
    total++;
    if (cpu_gnt !== 1'b1) begin
      bad++; $display("FAIL rst_pre_gnt got=%b want=1", cpu_gnt);
    end
    @(negedge clk);
    reset = 1'b1; disp_req = 1'b1; cpu_req = 1'b1;
    #1;
    total++;
    if ({disp_gnt, cpu_gnt, mem_we, cpu_rvalid, disp_rvalid} !== 5'b0) begin
      bad++; $display("FAIL rst_during got=%b want=00000", {disp_gnt, cpu_gnt, mem_we, cpu_rvalid, disp_rvalid});
    end
    @(negedge clk);
    reset = 1'b0; disp_req = 1'b0; cpu_req = 1'b0;
    #1;
    total++;
    if (cpu_rvalid !== 1'b0 || stall_cnt !== 32'd0) begin
      bad++; $display("FAIL rst_after got=%b/%0d want=0/0", cpu_rvalid, stall_cnt);
    end
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd50;
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    total++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h77) begin
      bad++; $display("FAIL rst_write_kept got=%b/%h want=1/77", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_stall_saturate();
    logic [31:0] exp_cnt [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    do_reset();
    @(negedge clk);
    force dut.r_stall_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.r_stall_cnt;
    disp_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      total++;
      if (stall_cnt !== exp_cnt[c]) begin
        bad++; $display("FAIL sat c=%0d got=%h want=%h", c, stall_cnt, exp_cnt[c]);
      end
    end
    disp_req = 1'b0; cpu_req = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) vram[a] = 8'(a) ^ 8'h5A;
    reset = 1'b1; disp_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    disp_addr = '0; cpu_addr = '0; cpu_wdata = '0;
    test_reset();
    test_display_stream();
    test_cpu_write_read();
    test_contention();
    test_cpu_drop();
    test_reset_mid_op();
    test_stall_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port VRAM between the processor's load/store unit and the display scan-out reader, both running on the CPU clock. Display reads have priority so scan-out never stalls behind interpolation writes. A bounded-streak rule guarantees the CPU forward progress while a frame is being scanned. Sits between the `mide_cpu` memory stage, the display address generator, and the VRAM macro.

## Interface
Parameters:
- ADDR_W, 32, address width for both requesters and VRAM
- DATA_W, 8, pixel/data width
- MAX_STREAK, 4, consecutive display grants allowed while the CPU is waiting before the CPU is forced a slot (≥1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- disp_req  in  1  display read request
- disp_addr  in  ADDR_W  display read address
- disp_gnt  out  1  display request accepted this cycle
- disp_rvalid  out  1  disp_rdata valid
- disp_rdata  out  DATA_W  read data to display
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_rvalid  out  1  cpu_rdata valid (reads only)
- cpu_rdata  out  DATA_W  read data to CPU
- mem_addr  out  ADDR_W  VRAM address
- mem_we  out  1  VRAM write enable
- mem_wdata  out  DATA_W  VRAM write data
- mem_rdata  in  DATA_W  VRAM read data, valid one cycle after address
- cpu_stall_cnt  out  32  saturating count of cycles with cpu_req high and cpu_gnt low

## Operation
- At most one grant per cycle; grants are combinational from current requests and registered streak state.
- Arbitration: only disp_req → display; only cpu_req → CPU; both → display unless streak == MAX_STREAK, then CPU.
- Streak counter (width clog2(MAX_STREAK+1)): +1 on each display grant while cpu_req high; cleared on CPU grant or any cycle cpu_req is low. Never exceeds MAX_STREAK.
- Memory drive: mem_addr/mem_we/mem_wdata from the winner; display always mem_we=0. No grant → mem_we=0, mem_addr holds last value (don't care).
- Read return: disp_rvalid registered = disp_gnt of previous cycle; cpu_rvalid registered = cpu_gnt & ~cpu_we of previous cycle. disp_rdata and cpu_rdata both wire mem_rdata; meaningful only with their rvalid.
- CPU writes produce no rvalid; write takes effect at the grant edge.
- Requester rule: req, addr, we, wdata held stable until gnt seen high; a new request may be presented the cycle after gnt. Arbiter does not check this.
- cpu_stall_cnt increments each cycle cpu_req & ~cpu_gnt; saturates at 0xFFFFFFFF.

## Timing
- Grant latency 0 cycles (same cycle as req when winning); read data latency 1 cycle after grant.
- Back-to-back grants to the same requester every cycle allowed; throughput 1 access/cycle.
- Worst-case CPU wait under continuous display requests: MAX_STREAK cycles.
- Reset (sampled at edge): streak=0, disp_rvalid=0, cpu_rvalid=0, cpu_stall_cnt=0. While reset is high, disp_gnt=0, cpu_gnt=0, mem_we=0 combinationally; no stall counting.
- Reset mid-operation: an access granted in the cycle before reset still writes memory, but its rvalid is cleared by reset and never delivered.
- Simultaneous request arrival on the cycle streak reaches MAX_STREAK: CPU wins that cycle, streak clears the next edge.
- cpu_req dropping (e.g. CPU reset) clears streak; display resumes uninterrupted priority.

## Test plan
- Display-only stream, addresses 0..7 back-to-back, VRAM preloaded with addr^0x5A → disp_gnt high every cycle, disp_rvalid from cycle 1, disp_rdata = 0x5A,0x5B,…,0x5D; cpu_stall_cnt = 0.
- CPU write 0x3C to addr 100 then read addr 100, no display traffic → two consecutive grants, no rvalid for write, cpu_rvalid one cycle after read grant with cpu_rdata = 0x3C.
- Continuous disp_req and cpu_req (read addr 7), MAX_STREAK=4 → display granted 4 cycles, CPU granted cycle 5, cpu_stall_cnt = 4, display resumes cycle 6.
- Contention where cpu_req drops after 2 display grants then reasserts → streak cleared, CPU waits full 4 more cycles; stall count reflects only cycles with cpu_req high.
- Reset asserted the cycle after a CPU read grant → cpu_rvalid stays 0, all grants 0 during reset, counters 0 after release.
- Force cpu_stall_cnt near 0xFFFFFFFE (starved CPU via preload/force) → saturates at 0xFFFFFFFF, no wrap.
